// File: rtl/current_based_tt_um_lif.sv
// -----------------------------------------------------------------------------
// current_based_tt_um_lif
//   Current-based leaky integrate-and-fire neuron in a Tiny Tapeout user-module
//   wrapper. A synaptic current I integrates ui_in and decays by I>>CUR_SHIFT.
//   The membrane V integrates I, leaks by V>>LEAK_SHIFT, and fires a one-cycle
//   registered spike when it reaches the threshold. After each spike V is held
//   at 0 for REFRACT_CYCLES enabled cycles.
//
// Optional build macro: LIF_SEG_DISPLAY_EN
//   defined   : uo_out[6:0] = seven-segment glyph (a=bit0..g=bit6) of V[7:4]
//   undefined : uo_out[6:0] = V[7:1]
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   ena     in   1  design enable; all state frozen when low
//   ui_in   in   8  unsigned input current sample
//   uio_in  in   8  runtime threshold; 0 selects THRESHOLD
//   uo_out  out  8  [7] spike, [6:0] membrane display
//   uio_out out  8  tied 0
//   uio_oe  out  8  tied 0 (bidir pins are inputs)
// -----------------------------------------------------------------------------
module current_based_tt_um_lif #(
    parameter int LEAK_SHIFT     = 4,
    parameter int CUR_SHIFT      = 2,
    parameter int THRESHOLD      = 200,
    parameter int REFRACT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES + 1) : 1;

    logic [7:0]    r_cur;
    logic [7:0]    r_vmem;
    logic [CW-1:0] r_ref;
    logic          r_spike;

    logic [8:0]    w_cur_sum;
    logic [7:0]    w_cur_next;
    logic [8:0]    w_v_sum;
    logic [7:0]    w_v_next;
    logic [7:0]    w_thr;
    logic          w_fire;
    logic [6:0]    w_disp;

    // Decayed value never underflows (x - (x>>s) >= 0), so one extra bit is
    // enough to catch the carry from the add before clamping.
    assign w_cur_sum  = {1'b0, r_cur - (r_cur >> CUR_SHIFT)} + {1'b0, ui_in};
    assign w_cur_next = w_cur_sum[8] ? 8'hFF : w_cur_sum[7:0];

    // Membrane uses the pre-edge current, not w_cur_next.
    assign w_v_sum    = {1'b0, r_vmem - (r_vmem >> LEAK_SHIFT)} + {1'b0, r_cur};
    assign w_v_next   = w_v_sum[8] ? 8'hFF : w_v_sum[7:0];

    assign w_thr      = (uio_in != 8'd0) ? uio_in : 8'(THRESHOLD);
    assign w_fire     = (w_v_next >= w_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur   <= '0;
            r_vmem  <= '0;
            r_ref   <= '0;
            r_spike <= 1'b0;
        end else if (ena) begin
            r_cur <= w_cur_next;
            if (r_ref != '0) begin
                // Refractory: membrane clamped, current keeps integrating.
                r_vmem  <= '0;
                r_ref   <= r_ref - CW'(1);
                r_spike <= 1'b0;
            end else if (w_fire) begin
                r_vmem  <= '0;
                r_ref   <= CW'(REFRACT_CYCLES);
                r_spike <= 1'b1;
            end else begin
                r_vmem  <= w_v_next;
                r_spike <= 1'b0;
            end
        end
    end

`ifdef LIF_SEG_DISPLAY_EN
    always_comb begin
        w_disp = 7'h00;
        case (r_vmem[7:4])
            4'h0: w_disp = 7'h3F;
            4'h1: w_disp = 7'h06;
            4'h2: w_disp = 7'h5B;
            4'h3: w_disp = 7'h4F;
            4'h4: w_disp = 7'h66;
            4'h5: w_disp = 7'h6D;
            4'h6: w_disp = 7'h7D;
            4'h7: w_disp = 7'h07;
            4'h8: w_disp = 7'h7F;
            4'h9: w_disp = 7'h6F;
            4'hA: w_disp = 7'h77;
            4'hB: w_disp = 7'h7C;
            4'hC: w_disp = 7'h39;
            4'hD: w_disp = 7'h5E;
            4'hE: w_disp = 7'h79;
            4'hF: w_disp = 7'h71;
            default: w_disp = 7'h00;
        endcase
    end
`else
    assign w_disp = r_vmem[7:1];
`endif

    assign uo_out  = {r_spike, w_disp};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_current_based_tt_um_lif.sv
module tb_current_based_tt_um_lif;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    current_based_tt_um_lif dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // One enabled/disabled clock edge: inputs and expected state after the edge.
    typedef struct {
        string      name;
        logic       en;
        logic [7:0] ui;
        logic [7:0] uio;
        logic       spk;
        logic [7:0] v;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb_q[$];
    string      sb_name[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    function automatic logic [7:0] disp(input logic spk, input logic [7:0] v);
        logic [6:0] seg;
`ifdef LIF_SEG_DISPLAY_EN
        logic [6:0] glyph [16];
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        seg = glyph[v[7:4]];
`else
        seg = v[7:1];
`endif
        return {spk, seg};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic en, input logic [7:0] ui,
                       input logic [7:0] uio, input logic spk, input logic [7:0] v);
        vec_t t;
        t.name = nm; t.en = en; t.ui = ui; t.uio = uio; t.spk = spk; t.v = v;
        tbl.push_back(t);
    endtask

    // Drive at negedge, push expectation, check 1ns after the rising edge.
    task automatic apply(input vec_t t);
        @(negedge clk);
        ena = t.en; ui_in = t.ui; uio_in = t.uio;
        sb_q.push_back(disp(t.spk, t.v));
        sb_name.push_back(t.name);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_empty %s: got nothing want entry", t.name);
        end else begin
            chk(sb_name.pop_front(), uo_out, sb_q.pop_front());
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    // Leaves rst_n released at a negedge with ui_in=0; the next edge sees all
    // zero state and zero input, so it is a no-op.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'd0; uio_in = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset holds everything at zero even with active inputs.
        rst_n = 1'b0; ena = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ui_in = (i < 10) ? 8'd0 : 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            chk("rst_uo", uo_out, 8'h00);
            chk("rst_uio_oe", uio_oe, 8'h00);
            chk("rst_uio_out", uio_out, 8'h00);
        end

        // Default threshold sequence with refractory and resume.
        do_reset();
        add("A_e1", 1, 10, 0, 0, 0);   add("A_e2", 1, 10, 0, 0, 10);
        add("A_e3", 1, 10, 0, 0, 28);  add("A_e4", 1, 10, 0, 0, 51);
        add("A_e5", 1, 10, 0, 0, 76);  add("A_e6", 1, 10, 0, 0, 103);
        add("A_e7", 1, 10, 0, 0, 131); add("A_e8", 1, 10, 0, 0, 159);
        add("A_e9", 1, 10, 0, 0, 187); add("A_e10_fire", 1, 10, 0, 1, 0);
        for (int i = 11; i <= 14; i++) add($sformatf("A_ref%0d", i), 1, 10, 0, 0, 0);
        add("A_e15", 1, 10, 0, 0, 40); add("A_e16", 1, 10, 0, 0, 78);
        run_tbl();

        // Runtime threshold 20 overrides default.
        do_reset();
        add("B_e1", 1, 10, 20, 0, 0);  add("B_e2", 1, 10, 20, 0, 10);
        add("B_e3_fire", 1, 10, 20, 1, 0);
        for (int i = 4; i <= 7; i++) add($sformatf("B_ref%0d", i), 1, 10, 20, 0, 0);
        add("B_e8_fire", 1, 10, 20, 1, 0);
        run_tbl();

        // Vc exactly equal to threshold fires; one above does not.
        do_reset();
        add("C28_e1", 1, 10, 28, 0, 0); add("C28_e2", 1, 10, 28, 0, 10);
        add("C28_e3_eq", 1, 10, 28, 1, 0);
        run_tbl();
        do_reset();
        add("C29_e1", 1, 10, 29, 0, 0); add("C29_e2", 1, 10, 29, 0, 10);
        add("C29_e3_below", 1, 10, 29, 0, 28); add("C29_e4", 1, 10, 29, 1, 0);
        run_tbl();

        // Saturated current: spike on edge 2 then every 5th edge.
        do_reset();
        for (int e = 1; e <= 17; e++)
            add($sformatf("D_e%0d", e), 1, 255, 0, (e >= 2 && (e - 2) % 5 == 0), 0);
        run_tbl();

        // Membrane saturation: 240-15+40 clamps to 255 and meets thr=255.
        do_reset();
        add("E_e1", 1, 10, 255, 0, 0);   add("E_e2", 1, 10, 255, 0, 10);
        add("E_e3", 1, 10, 255, 0, 28);  add("E_e4", 1, 10, 255, 0, 51);
        add("E_e5", 1, 10, 255, 0, 76);  add("E_e6", 1, 10, 255, 0, 103);
        add("E_e7", 1, 10, 255, 0, 131); add("E_e8", 1, 10, 255, 0, 159);
        add("E_e9", 1, 10, 255, 0, 187); add("E_e10", 1, 10, 255, 0, 214);
        add("E_e11", 1, 10, 255, 0, 240); add("E_e12_sat", 1, 10, 255, 1, 0);
        run_tbl();

        // Freeze mid-integration, then continue from 131.
        do_reset();
        add("F_e1", 1, 10, 0, 0, 0);   add("F_e2", 1, 10, 0, 0, 10);
        add("F_e3", 1, 10, 0, 0, 28);  add("F_e4", 1, 10, 0, 0, 51);
        add("F_e5", 1, 10, 0, 0, 76);  add("F_e6", 1, 10, 0, 0, 103);
        add("F_e7", 1, 10, 0, 0, 131);
        for (int i = 0; i < 5; i++) add($sformatf("F_hold%0d", i), 0, 200, 0, 0, 131);
        add("F_e8", 1, 10, 0, 0, 159); add("F_e9", 1, 10, 0, 0, 187);
        add("F_e10_fire", 1, 10, 0, 1, 0);
        run_tbl();

        // Spike register holds while disabled; refractory counts enabled edges only.
        do_reset();
        add("G_e1", 1, 255, 0, 0, 0);  add("G_e2_fire", 1, 255, 0, 1, 0);
        add("G_hold0", 0, 255, 0, 1, 0); add("G_hold1", 0, 255, 0, 1, 0);
        for (int i = 3; i <= 6; i++) add($sformatf("G_ref%0d", i), 1, 255, 0, 0, 0);
        add("G_e7_fire", 1, 255, 0, 1, 0);
        run_tbl();

        // Async reset right after a spike (refractory armed) clears at once.
        do_reset();
        add("H_e1", 1, 255, 0, 0, 0);  add("H_e2_fire", 1, 255, 0, 1, 0);
        run_tbl();
        #2;
        rst_n = 1'b0;
        #1;
        chk("H_async_uo", uo_out, 8'h00);
        chk("H_async_oe", uio_oe, 8'h00);
        @(negedge clk);
        ui_in = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        add("H_post_e1", 1, 255, 0, 0, 0); add("H_post_e2_fire", 1, 255, 0, 1, 0);
        run_tbl();

        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Absolute time bound in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/current_based_tt_um_lif.md
Name: current_based_tt_um_lif

Overview:
Current-based leaky integrate-and-fire (LIF) neuron in a Tiny Tapeout user-module wrapper.
- An 8-bit synaptic current integrates ui_in and decays.
- An 8-bit membrane potential integrates that current, leaks, and fires a one-cycle spike when it reaches a threshold.
- A refractory period follows each spike.
- Spike and membrane state drive the dedicated outputs; the bidirectional pins are inputs only and carry an optional runtime threshold.

Parameters:
- LEAK_SHIFT, 4: membrane leak per step = V >> LEAK_SHIFT.
- CUR_SHIFT, 2: current decay per step = I >> CUR_SHIFT.
- THRESHOLD, 200: default firing threshold, used when uio_in == 0.
- REFRACT_CYCLES, 4: enabled cycles V is held at 0 after a spike.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; state frozen when low.
- ui_in  in  8  unsigned input current sample, added every enabled cycle.
- uio_in  in  8  runtime threshold; 0 selects THRESHOLD.
- uo_out  out  8  [7] spike, [6:0] membrane display.
- uio_out  out  8  tied 0.
- uio_oe  out  8  tied 0 (all bidir pins are inputs).

Behaviour:
- Reset (rst_n=0, async): I=0, V=0, refractory counter=0, spike=0, so uo_out=0. uio_out and uio_oe are constant 0.
- ena=0: I, V, counter and spike hold their values; nothing updates.
- Per enabled rising edge, all updates use pre-edge register values.
- Current update:
  - I_next = sat255(I - (I>>CUR_SHIFT) + ui_in).
  - Computed at 9+ bits, then clamped to 255.
- Threshold: thr = (uio_in != 0) ? uio_in : THRESHOLD (sampled combinationally).
- Refractory branch (counter != 0):
  - V <= 0, counter decrements, spike <= 0.
  - I still updates.
- Normal branch (counter == 0):
  - Vc = sat255(V - (V>>LEAK_SHIFT) + I).
  - If Vc >= thr: spike <= 1, V <= 0, counter <= REFRACT_CYCLES.
  - Else: V <= Vc, spike <= 0.
- Spike is registered: high for exactly one clock after the firing edge.
  - Minimum spike spacing is REFRACT_CYCLES+1 enabled edges, plus integration time.
- uo_out[7] = spike register.
- uo_out[6:0] = V[7:1]; see Optional Feature.
- Boundaries:
  - Saturation clamps at 255 and never wraps.
  - Leak of V < 16 is 0, so a sub-threshold V with I=0 holds.
  - Vc exactly equal to thr fires.
  - A reset mid-refractory clears the counter immediately.

Optional Feature:
- Macro LIF_SEG_DISPLAY_EN.
- Defined: uo_out[6:0] is an active-high seven-segment decode of hex digit V[7:4].
  - Segment mapping: a=bit0 … g=bit6, standard 0-F glyphs.
  - Value 0 → 7'h3F, 1 → 7'h06, C → 7'h39.
- Not defined: uo_out[6:0] = V[7:1].
- uo_out[7] is the spike in both builds.

Test Plan:
- Reset with ui_in=0, ena=1 for 20 cycles → uo_out=0 throughout; uio_oe=0; uio_out=0.
- Reset, then ui_in=10, uio_in=0:
  - V after edges 1..9 = 0,10,28,51,76,103,131,159,187.
  - Edge 10 computes 214 ≥ 200 → uo_out[7]=1 for one cycle, V=0.
  - V stays 0 for the next 4 edges, then integration resumes.
- ui_in=10, uio_in=20 → spike on edge 3 (Vc=28); verify the runtime threshold overrides THRESHOLD.
- ui_in=255 constant → I saturates at 255; spike on edge 2, then every 5th edge (refractory 4); no wraparound.
- Mid-integration (V=131), drop ena for 5 cycles → V, I unchanged and no spike; after re-enabling, the sequence continues from 131.
- Assert rst_n low asynchronously between clock edges during refractory → all outputs 0 immediately; first spike after release follows the reset-start sequence.
